uart_tx_framer: RTL and testbench

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 49 ++++
 rtl/uart_tx_framer.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx_framer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: parity mode and framer states.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Clocks per line bit; fractional remainder is dropped.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit timer: tick pulses once every DIV clocks; restart re-phases it so the
// first tick lands DIV clocks after the restart edge.
module uart_baud_tick #(
  parameter int unsigned DIV = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_baud_tick: DIV must be at least 2");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next count and registered tick, asserted while the count sits on LAST.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    tick_d = !restart && (cnt_d == LAST);
  end

  // Timer state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DATA_BITS payload LSB first, optional
// parity bit, STOP_BITS stop bits. Parity support is compiled in only when
// the macro UART_TX_PARITY_EN is defined; otherwise PARITY is ignored.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 25_000_000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter parity_t     PARITY    = PARITY_NONE,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 ready,
  output logic                 frame_done
);

  localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD_RATE);
  localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_framer: CLK_HZ/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_framer: DATA_BITS must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_framer: STOP_BITS must be 1 or 2");
  end
  if (PARITY != PARITY_NONE && PARITY != PARITY_EVEN && PARITY != PARITY_ODD) begin : g_bad_parity
    $error("uart_tx_framer: illegal PARITY mode");
  end

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic                 accept;
  logic                 tick;
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_EN  = (PARITY != PARITY_NONE);
  localparam logic PAR_ODD = (PARITY == PARITY_ODD);
  logic                 par_q, par_d;
`endif

  assign accept = send && ready_q;

  // Bit timer re-phased on every acceptance.
  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .restart (accept),
    .tick    (tick)
  );

  // Next-state, datapath and line value for the following cycle.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d   = ST_START;
          shift_d   = data;
          bit_cnt_d = '0;
          tx_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d     = (^data) ^ PAR_ODD;
`endif
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            if (PAR_EN) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d    = ST_STOP;
              stop_cnt_d = 1'b0;
              tx_d       = 1'b1;
            end
`else
            state_d    = ST_STOP;
            stop_cnt_d = 1'b0;
            tx_d       = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // Framer state and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity of the accepted payload.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  assign tx         = tx_q;
  assign ready      = ready_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Testbench for uart_tx_framer: four configurations (8N1, 7N2, 8E1, 8O1)
// checked cycle by cycle against a frame-level reference model.
module tb_uart_tx_framer;

  localparam int unsigned DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] send_v;
  logic [8:0] data_v [4];
  logic [3:0] tx_v;
  logic [3:0] ready_v;
  logic [3:0] done_v;

  int n_tests = 0;
  int n_fail  = 0;
  int db [4];
  int sb [4];
  int pm [4];
  int frames_exp [4];
  int done_cnt [4];

  always #5 clk = ~clk;

  uart_tx_framer #(.CLK_HZ(1_000_000), .BAUD_RATE(250_000), .DATA_BITS(8),
                   .PARITY(uart_pkg::PARITY_NONE), .STOP_BITS(1)) u_8n1 (
    .clock(clk), .reset_n(reset_n), .send(send_v[0]), .data(data_v[0][7:0]),
    .tx(tx_v[0]), .ready(ready_v[0]), .frame_done(done_v[0]));

  uart_tx_framer #(.CLK_HZ(1_000_000), .BAUD_RATE(250_000), .DATA_BITS(7),
                   .PARITY(uart_pkg::PARITY_NONE), .STOP_BITS(2)) u_7n2 (
    .clock(clk), .reset_n(reset_n), .send(send_v[1]), .data(data_v[1][6:0]),
    .tx(tx_v[1]), .ready(ready_v[1]), .frame_done(done_v[1]));

  uart_tx_framer #(.CLK_HZ(1_000_000), .BAUD_RATE(250_000), .DATA_BITS(8),
                   .PARITY(uart_pkg::PARITY_EVEN), .STOP_BITS(1)) u_8e1 (
    .clock(clk), .reset_n(reset_n), .send(send_v[2]), .data(data_v[2][7:0]),
    .tx(tx_v[2]), .ready(ready_v[2]), .frame_done(done_v[2]));

  uart_tx_framer #(.CLK_HZ(1_000_000), .BAUD_RATE(250_000), .DATA_BITS(8),
                   .PARITY(uart_pkg::PARITY_ODD), .STOP_BITS(1)) u_8o1 (
    .clock(clk), .reset_n(reset_n), .send(send_v[3]), .data(data_v[3][7:0]),
    .tx(tx_v[3]), .ready(ready_v[3]), .frame_done(done_v[3]));

  // Count completed frames per instance.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (done_v[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int par_bits(input int inst);
    return (PAR_EN && pm[inst] != 0) ? 1 : 0;
  endfunction

  function automatic int frame_len(input int inst);
    return 1 + db[inst] + par_bits(inst) + sb[inst];
  endfunction

  // Line value of bit slot idx of a frame carrying val.
  function automatic bit exp_bit(input int inst, input logic [8:0] val, input int idx);
    int ones;
    ones = 0;
    for (int b = 0; b < db[inst]; b++) ones += int'(val[b]);
    if (idx == 0) return 1'b0;
    if (idx <= db[inst]) return val[idx-1];
    if (par_bits(inst) == 1 && idx == db[inst] + 1)
      return (pm[inst] == 1) ? bit'(ones % 2) : bit'(1 - ones % 2);
    return 1'b1;
  endfunction

  // Called at a negedge with the instance idle: request, then check every
  // line cycle and the completion cycle. Returns at the completion negedge.
  task automatic do_frame(input int inst, input logic [8:0] val, input bit keep,
                          input bit toggle, input bit poke);
    int len;
    len = frame_len(inst) * int'(DIV);
    data_v[inst] = val;
    send_v[inst] = 1'b1;
    check($sformatf("rdy_pre%0d", inst), 32'(ready_v[inst]), 32'd1);
    @(negedge clk);
    if (!keep) send_v[inst] = 1'b0;
    for (int k = 0; k < len; k++) begin
      if (k > 0) @(negedge clk);
      if (toggle) data_v[inst] = 9'($urandom);
      if (poke && !keep) send_v[inst] = (k == len / 2);
      check($sformatf("tx%0d_k%0d", inst, k), 32'(tx_v[inst]), 32'(exp_bit(inst, val, k / int'(DIV))));
      check($sformatf("rdy_busy%0d", inst), 32'(ready_v[inst]), 32'd0);
      check($sformatf("done_busy%0d", inst), 32'(done_v[inst]), 32'd0);
    end
    @(negedge clk);
    check($sformatf("done%0d", inst), 32'(done_v[inst]), 32'd1);
    check($sformatf("rdy_end%0d", inst), 32'(ready_v[inst]), 32'd1);
    check($sformatf("tx_gap%0d", inst), 32'(tx_v[inst]), 32'd1);
    frames_exp[inst]++;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("idle_tx%0d", i), 32'(tx_v[i]), 32'd1);
        check($sformatf("idle_done%0d", i), 32'(done_v[i]), 32'd0);
      end
    end
  endtask

  initial begin
    logic [8:0] v;
    db = '{8, 7, 8, 8};
    sb = '{1, 2, 1, 1};
    pm = '{0, 0, 1, 2};
    frames_exp = '{0, 0, 0, 0};
    done_cnt   = '{0, 0, 0, 0};
    send_v  = '0;
    for (int i = 0; i < 4; i++) data_v[i] = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_tx%0d", i), 32'(tx_v[i]), 32'd1);
      check($sformatf("rst_rdy%0d", i), 32'(ready_v[i]), 32'd1);
      check($sformatf("rst_done%0d", i), 32'(done_v[i]), 32'd0);
    end
    repeat (3) @(negedge clk);
    check("rst_rdy_hold", 32'(ready_v[0]), 32'd1);
    reset_n = 1'b1;

    // Directed frames; the first is requested in the first cycle out of reset.
    do_frame(0, 9'h055, 1'b0, 1'b0, 1'b0);
    idle(3);
    do_frame(2, 9'h007, 1'b0, 1'b0, 1'b0);
    idle(2);
    do_frame(3, 9'h007, 1'b0, 1'b0, 1'b0);
    idle(2);
    do_frame(1, 9'h041, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Back-to-back with send held and data churning mid-frame.
    do_frame(0, 9'h0A5, 1'b1, 1'b1, 1'b0);
    do_frame(0, 9'h03C, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Request pulsed while busy must be ignored.
    do_frame(0, 9'($urandom), 1'b0, 1'b0, 1'b1);
    idle(4);

    // Reset during data bit 3, then a clean frame.
    v = 9'($urandom);
    data_v[0] = v;
    send_v[0] = 1'b1;
    @(negedge clk);
    send_v[0] = 1'b0;
    for (int k = 0; k < 17; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("pre_rst_tx_k%0d", k), 32'(tx_v[0]), 32'(exp_bit(0, v, k / int'(DIV))));
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx_v[0]), 32'd1);
    check("mid_rst_rdy", 32'(ready_v[0]), 32'd1);
    check("mid_rst_done", 32'(done_v[0]), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("in_rst_tx", 32'(tx_v[0]), 32'd1);
      check("in_rst_done", 32'(done_v[0]), 32'd0);
    end
    reset_n = 1'b1;
    do_frame(0, 9'h081, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Randomized frames across all configurations.
    repeat (16) begin
      do_frame(int'($urandom_range(0, 3)), 9'($urandom), 1'b0,
               1'($urandom), 1'($urandom));
      idle(int'($urandom_range(0, 3)));
    end

    idle(2);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("frames%0d", i), 32'(done_cnt[i]), 32'(frames_exp[i]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
